spi_helpers_minion_adapter_mc: RTL and testbench
================================================

// Module: spi_helpers_minion_adapter_mc
// PURPOSE
//  Multi-channel successor of the SPI minion push/pull adapter. Converts the SPI minion push/pull
//  interface into NCH independent val/rdy channel pairs. A channel-address field in each SPI
//  payload steers writes into per-channel minion->controller queues and reads out of per-channel
//  controller->minion queues. Adds sticky overflow/underflow error flags and per-channel parity.
//  Sits between the SPI minion shift-register block and NCH on-chip consumers/producers.
// PARAMETERS
//  NBITS  10  SPI packet width; 2 flag bits + (NBITS-2) data bits (AW addr + PW payload)
//  NCH    4   channel count; power of 2, >=2; AW=$clog2(NCH), PW=NBITS-2-AW (must be >=1)
//  DEPTH  2   entries per queue, each direction, each channel; >=1
// PORTS
//  clk               in   1          clock
//  reset_n           in   1          asynchronous active-low reset
//  push_en           in   1          SPI push strobe (1 cycle per SPI transaction)
//  push_msg_val_wrt  in   1          transaction carries write data
//  push_msg_val_rd   in   1          transaction requests read data
//  push_msg_data     in   NBITS-2    {addr[AW-1:0], payload[PW-1:0]}, addr in MSBs
//  pull_en           in   1          SPI pull strobe (same cycle as push_en)
//  pull_msg_val      out  1          pull_msg_data holds valid read data
//  pull_msg_spc      out  1          every mc queue can take one more write
//  pull_msg_data     out  NBITS-2    {addr, payload} of read data; all-zero when not valid
//  recv_msg          in   NCH*PW     per-channel controller->minion payload, ch c at [c*PW+:PW]
//  recv_val          in   NCH        per-channel valid
//  recv_rdy          out  NCH        per-channel ready
//  send_msg          out  NCH*PW     per-channel minion->controller payload
//  send_val          out  NCH        per-channel valid
//  send_rdy          in   NCH        per-channel ready
//  parity            out  NCH        parity[c] = ^send_msg[c] & send_val[c]
//  err_ovf           out  1          sticky: write to a full mc queue was dropped
//  err_udf           out  1          sticky: read from an empty cm queue
//  err_clr           in   1          synchronous clear of both error flags
// BEHAVIOUR
//  - Reset (reset_n low, async): all queues empty. While low: recv_rdy=0, send_val=0,
//    pull_msg_val=0, pull_msg_spc=0, pull_msg_data=0, parity=0, err_ovf=err_udf=0.
//    Reset mid-transfer discards all queued data.
//  - Queues: 2*NCH normal FIFOs, DEPTH entries each, in-order, no bypass. Enq->deq latency is
//    1 cycle; full queue: rdy=0; empty queue: val=0. Simultaneous enq+deq on a non-empty queue:
//    both occur, occupancy unchanged. rdy/val derive from occupancy registers only (no
//    combinational val->rdy path).
//  - Write: wr = push_en & push_msg_val_wrt. ch = push_msg_data[NBITS-3 -: AW]. If
//    mc[ch] not full, payload is enqueued. Else write dropped, err_ovf<=1.
//  - Read: rd = pull_en & push_msg_val_rd; uses same ch. pull_msg_val = rd & cm[ch] non-empty;
//    when valid: cm[ch] dequeued same cycle, pull_msg_data={ch, head payload}. rd on empty cm[ch]:
//    no dequeue, pull_msg_data=0, err_udf<=1.
//    Write and read in one transaction may target the same channel (different queues).
//  - pull_msg_spc (combinational) = AND over c of (free_mc[c] - (wr & ch==c)) >= 1, i.e.
//    space remains for the next transaction after this cycle's write.
//  - recv side: cm[c] enqueues when recv_val[c] & recv_rdy[c]; recv_rdy[c] = cm[c] not full.
//  - send side: send_val[c] = mc[c] non-empty; dequeue on send_val[c] & send_rdy[c].
//  - Error flags: set on event, hold until err_clr. Set and err_clr in same cycle -> flag stays 1.
//  - Pointers wrap modulo DEPTH; occupancy counters are $clog2(DEPTH)+1 bits wide, range 0..DEPTH.
// TESTING
//  1 Reset: hold reset_n=0 with recv_val=all 1s. Expect recv_rdy=0, send_val=0, errors 0.
//    After release: recv_rdy=all 1s, pull_msg_spc=1.
//  2 Write steer: NBITS=10,NCH=4; push wr, data=8'b10_010110 -> next cycle send_val=4'b0100,
//    ch2 payload=6'h16, parity[2]=1; other channels idle.
//  3 Read: recv_val[1]=1, payload=6'h2A; then rd, addr=1 -> pull_msg_val=1,
//    pull_msg_data=8'b01_101010. rd on addr=3 (empty) -> pull_msg_val=0, data=0, err_udf=1.
//  4 Full/overflow: DEPTH=2, send_rdy=0; write ch0 twice -> after the 2nd write spc=0.
//    3rd write dropped, err_ovf=1. err_clr -> err_ovf=0. Drain: order preserved.
//  5 Simultaneous: same transaction wr ch3 + rd ch3 with cm[3] holding 1 entry -> read valid,
//    mc[3] enqueued; also recv enq + SPI deq on same cm queue keeps occupancy constant.
//  6 Async reset asserted mid-stream with queues half full -> all outputs reset value
//    immediately (before next clk edge); after release all queues empty.

Source files
------------

// File: rtl/spi_helpers_minion_adapter_mc.sv
// SPI minion push/pull adapter, multi-channel: an address field in each SPI payload
// steers writes into per-channel minion->controller (mc) queues and reads out of
// per-channel controller->minion (cm) queues. Sticky overflow/underflow flags.
module spi_helpers_minion_adapter_mc #(
  parameter int unsigned NBITS = 10,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(NCH),
  localparam int unsigned PW   = NBITS - 2 - AW
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_push_en,
  input  logic                i_push_msg_val_wrt,
  input  logic                i_push_msg_val_rd,
  input  logic [NBITS-3:0]    i_push_msg_data,
  input  logic                i_pull_en,
  output logic                o_pull_msg_val,
  output logic                o_pull_msg_spc,
  output logic [NBITS-3:0]    o_pull_msg_data,
  input  logic [NCH*PW-1:0]   i_recv_msg,
  input  logic [NCH-1:0]      i_recv_val,
  output logic [NCH-1:0]      o_recv_rdy,
  output logic [NCH*PW-1:0]   o_send_msg,
  output logic [NCH-1:0]      o_send_val,
  input  logic [NCH-1:0]      i_send_rdy,
  output logic [NCH-1:0]      o_parity,
  output logic                o_err_ovf,
  output logic                o_err_udf,
  input  logic                i_err_clr
);

  localparam int unsigned CW   = $clog2(DEPTH) + 1;
  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Queue storage and bookkeeping, one mc and one cm queue per channel
  logic [PW-1:0]   r_mc_mem [NCH][DEPTH];
  logic [PTRW-1:0] r_mc_wp  [NCH];
  logic [PTRW-1:0] r_mc_rp  [NCH];
  logic [CW-1:0]   r_mc_cnt [NCH];
  logic [PW-1:0]   r_cm_mem [NCH][DEPTH];
  logic [PTRW-1:0] r_cm_wp  [NCH];
  logic [PTRW-1:0] r_cm_rp  [NCH];
  logic [CW-1:0]   r_cm_cnt [NCH];
  logic            r_err_ovf;
  logic            r_err_udf;

  logic [AW-1:0]   w_ch;
  logic [PW-1:0]   w_pay;
  logic            w_wr;
  logic            w_rd;
  logic [NCH-1:0]  w_mc_full;
  logic [NCH-1:0]  w_mc_empty;
  logic [NCH-1:0]  w_cm_full;
  logic [NCH-1:0]  w_cm_empty;
  logic [NCH-1:0]  w_mc_enq;
  logic [NCH-1:0]  w_mc_deq;
  logic [NCH-1:0]  w_cm_enq;
  logic [NCH-1:0]  w_cm_deq;
  logic [NCH-1:0]  w_spc;
  logic            w_ovf_set;
  logic            w_udf_set;

  assign w_ch  = i_push_msg_data[NBITS-3 -: AW];
  assign w_pay = i_push_msg_data[PW-1:0];
  assign w_wr  = i_push_en & i_push_msg_val_wrt;
  assign w_rd  = i_pull_en & i_push_msg_val_rd;

  // Per-channel status and handshake decode; all flow control comes from occupancy only
  always_comb begin
    w_mc_full  = '0;
    w_mc_empty = '0;
    w_cm_full  = '0;
    w_cm_empty = '0;
    w_mc_enq   = '0;
    w_mc_deq   = '0;
    w_cm_enq   = '0;
    w_cm_deq   = '0;
    w_spc      = '0;
    for (int c = 0; c < NCH; c++) begin
      w_mc_full[c]  = (r_mc_cnt[c] == CW'(DEPTH));
      w_mc_empty[c] = (r_mc_cnt[c] == '0);
      w_cm_full[c]  = (r_cm_cnt[c] == CW'(DEPTH));
      w_cm_empty[c] = (r_cm_cnt[c] == '0);
      w_mc_enq[c]   = w_wr & (w_ch == AW'(c)) & ~w_mc_full[c];
      w_mc_deq[c]   = ~w_mc_empty[c] & i_send_rdy[c];
      w_cm_enq[c]   = i_recv_val[c] & ~w_cm_full[c] & i_reset_n;
      w_cm_deq[c]   = w_rd & (w_ch == AW'(c)) & ~w_cm_empty[c];
      // Space must remain for one more write after this cycle's write lands
      w_spc[c] = (({1'b0, r_mc_cnt[c]} + (CW+1)'(w_wr & (w_ch == AW'(c))))
                  < (CW+1)'(DEPTH));
    end
  end

  // Output drive; everything forced low while reset is held
  always_comb begin
    o_recv_rdy = '0;
    o_send_val = '0;
    o_send_msg = '0;
    o_parity   = '0;
    for (int c = 0; c < NCH; c++) begin
      o_recv_rdy[c] = ~w_cm_full[c] & i_reset_n;
      o_send_val[c] = ~w_mc_empty[c] & i_reset_n;
      if (o_send_val[c]) begin
        o_send_msg[c*PW +: PW] = r_mc_mem[c][r_mc_rp[c]];
      end
      o_parity[c] = (^o_send_msg[c*PW +: PW]) & o_send_val[c];
    end
    o_pull_msg_val  = w_rd & ~w_cm_empty[w_ch] & i_reset_n;
    o_pull_msg_data = o_pull_msg_val ? {w_ch, r_cm_mem[w_ch][r_cm_rp[w_ch]]} : '0;
    o_pull_msg_spc  = (&w_spc) & i_reset_n;
    o_err_ovf       = r_err_ovf;
    o_err_udf       = r_err_udf;
  end

  assign w_ovf_set = w_wr & w_mc_full[w_ch];
  assign w_udf_set = w_rd & w_cm_empty[w_ch];

  // Pointer and occupancy registers; reset empties every queue
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        r_mc_wp[c]  <= '0;
        r_mc_rp[c]  <= '0;
        r_mc_cnt[c] <= '0;
        r_cm_wp[c]  <= '0;
        r_cm_rp[c]  <= '0;
        r_cm_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_mc_enq[c]) begin
          r_mc_wp[c] <= (r_mc_wp[c] == PTRW'(DEPTH-1)) ? '0 : r_mc_wp[c] + 1'b1;
        end
        if (w_mc_deq[c]) begin
          r_mc_rp[c] <= (r_mc_rp[c] == PTRW'(DEPTH-1)) ? '0 : r_mc_rp[c] + 1'b1;
        end
        r_mc_cnt[c] <= r_mc_cnt[c] + CW'(w_mc_enq[c]) - CW'(w_mc_deq[c]);
        if (w_cm_enq[c]) begin
          r_cm_wp[c] <= (r_cm_wp[c] == PTRW'(DEPTH-1)) ? '0 : r_cm_wp[c] + 1'b1;
        end
        if (w_cm_deq[c]) begin
          r_cm_rp[c] <= (r_cm_rp[c] == PTRW'(DEPTH-1)) ? '0 : r_cm_rp[c] + 1'b1;
        end
        r_cm_cnt[c] <= r_cm_cnt[c] + CW'(w_cm_enq[c]) - CW'(w_cm_deq[c]);
      end
    end
  end

  // Queue payload storage; contents are meaningless while occupancy is zero, so no reset
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (w_mc_enq[c]) begin
        r_mc_mem[c][r_mc_wp[c]] <= w_pay;
      end
      if (w_cm_enq[c]) begin
        r_cm_mem[c][r_cm_wp[c]] <= i_recv_msg[c*PW +: PW];
      end
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      r_err_ovf <= w_ovf_set | (r_err_ovf & ~i_err_clr);
      r_err_udf <= w_udf_set | (r_err_udf & ~i_err_clr);
    end
  end

endmodule

// File: tb/tb_spi_helpers_minion_adapter_mc.sv
// Scoreboard bench for spi_helpers_minion_adapter_mc (NBITS=10, NCH=4, DEPTH=2).
module tb_spi_helpers_minion_adapter_mc;

  localparam int unsigned NBITS = 10;
  localparam int unsigned NCH   = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned PW    = 6;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              push_en, val_wrt, val_rd, pull_en;
  logic [7:0]        push_data;
  logic              pull_val, pull_spc;
  logic [7:0]        pull_data;
  logic [NCH*PW-1:0] recv_msg;
  logic [NCH-1:0]    recv_val, recv_rdy;
  logic [NCH*PW-1:0] send_msg;
  logic [NCH-1:0]    send_val, send_rdy, parity;
  logic              err_ovf, err_udf, err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_send_q[$];  // {ch, payload} in issue order
  logic [8:0] exp_pull_q[$];  // {val, data} per SPI transaction

  spi_helpers_minion_adapter_mc #(.NBITS(NBITS), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .i_clk              (clk),
    .i_reset_n          (reset_n),
    .i_push_en          (push_en),
    .i_push_msg_val_wrt (val_wrt),
    .i_push_msg_val_rd  (val_rd),
    .i_push_msg_data    (push_data),
    .i_pull_en          (pull_en),
    .o_pull_msg_val     (pull_val),
    .o_pull_msg_spc     (pull_spc),
    .o_pull_msg_data    (pull_data),
    .i_recv_msg         (recv_msg),
    .i_recv_val         (recv_val),
    .o_recv_rdy         (recv_rdy),
    .o_send_msg         (send_msg),
    .o_send_val         (send_val),
    .i_send_rdy         (send_rdy),
    .o_parity           (parity),
    .o_err_ovf          (err_ovf),
    .o_err_udf          (err_udf),
    .i_err_clr          (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI transaction; expectations are queued, the monitor checks the pull result
  task automatic txn(input bit wr, input bit rd, input logic [7:0] data, input bit acc,
                     input bit pv, input logic [7:0] pd, input bit spc);
    push_en   = 1'b1;
    pull_en   = 1'b1;
    val_wrt   = wr;
    val_rd    = rd;
    push_data = data;
    exp_pull_q.push_back({pv, pd});
    if (wr && acc) exp_send_q.push_back(data);
    @(negedge clk);
    check("pull_spc", 32'(pull_spc), 32'(spc));
    @(posedge clk);
    #1;
    push_en   = 1'b0;
    pull_en   = 1'b0;
    val_wrt   = 1'b0;
    val_rd    = 1'b0;
    push_data = '0;
  endtask

  task automatic recv1(input int ch, input logic [5:0] pay);
    recv_msg[ch*PW +: PW] = pay;
    recv_val[ch] = 1'b1;
    cyc(1);
    recv_val[ch] = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        if (send_val[c] && send_rdy[c]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < exp_send_q.size(); i++) begin
            if (idx < 0 && exp_send_q[i][7:6] == 2'(c)) idx = i;
          end
          if (idx < 0) begin
            check("send_unexpected", 32'(c), 32'hFFFF_FFFF);
          end else begin
            check("send_msg", 32'(send_msg[c*PW +: PW]), 32'(exp_send_q[idx][5:0]));
            exp_send_q.delete(idx);
          end
        end
      end
      if (pull_en) begin
        if (exp_pull_q.size() == 0) begin
          check("pull_unexpected", 32'(pull_val), 32'hFFFF_FFFF);
        end else begin
          logic [8:0] e;
          e = exp_pull_q.pop_front();
          check("pull_val", 32'(pull_val), 32'(e[8]));
          check("pull_data", 32'(pull_data), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; push_en = 0; val_wrt = 0; val_rd = 0; pull_en = 0; push_data = '0;
    recv_msg = '0; recv_val = 4'hF; send_rdy = '0; err_clr = 1'b0;

    // 1 Reset
    #1;
    check("rst_recv_rdy", 32'(recv_rdy), 32'h0);
    check("rst_send_val", 32'(send_val), 32'h0);
    check("rst_errs", 32'({err_ovf, err_udf}), 32'h0);
    check("rst_spc", 32'(pull_spc), 32'h0);
    cyc(2);
    reset_n = 1'b1;
    #1;
    check("rel_recv_rdy", 32'(recv_rdy), 32'hF);
    check("rel_spc", 32'(pull_spc), 32'h1);
    recv_val = '0;
    cyc(1);

    // 2 Write steer to ch2
    txn(1, 0, 8'b10_010110, 1, 0, 8'h00, 1);
    check("steer_send_val", 32'(send_val), 32'h4);
    check("steer_payload", 32'(send_msg[2*PW +: PW]), 32'h16);
    check("steer_parity", 32'(parity), 32'h4);
    send_rdy = 4'hF;
    cyc(2);
    send_rdy = '0;
    check("steer_drained", 32'(send_val), 32'h0);

    // 3 Read hit on ch1, then underflow on ch3
    recv1(1, 6'h2A);
    check("rd_recv_rdy", 32'(recv_rdy), 32'hF);
    txn(0, 1, 8'b01_000000, 0, 1, 8'b01_101010, 1);
    txn(0, 1, 8'b11_000000, 0, 0, 8'h00, 1);
    check("udf_set", 32'(err_udf), 32'h1);
    check("ovf_clean", 32'(err_ovf), 32'h0);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("udf_clr", 32'(err_udf), 32'h0);

    // 4 Fill ch0, overflow, clear, drain in order
    txn(1, 0, 8'b00_010001, 1, 0, 8'h00, 1);
    txn(1, 0, 8'b00_100010, 1, 0, 8'h00, 0);
    check("full_send_val", 32'(send_val), 32'h1);
    txn(1, 0, 8'b00_110011, 0, 0, 8'h00, 0);
    check("ovf_set", 32'(err_ovf), 32'h1);
    err_clr = 1'b1;
    txn(1, 0, 8'b00_110100, 0, 0, 8'h00, 0);
    err_clr = 1'b0;
    check("ovf_set_beats_clr", 32'(err_ovf), 32'h1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("ovf_clr", 32'(err_ovf), 32'h0);
    send_rdy = 4'h1;
    cyc(3);
    send_rdy = '0;
    check("ovf_drained", 32'(send_val), 32'h0);

    // 5 Simultaneous write+read on ch3, then recv enq + SPI deq on cm[3]
    recv1(3, 6'h05);
    txn(1, 1, 8'b11_111000, 1, 1, 8'b11_000101, 1);
    check("sim_send_val", 32'(send_val), 32'h8);
    check("sim_payload", 32'(send_msg[3*PW +: PW]), 32'h38);
    check("sim_parity", 32'(parity), 32'h8);
    check("sim_recv_rdy", 32'(recv_rdy), 32'hF);
    recv1(3, 6'h07);
    recv_msg[3*PW +: PW] = 6'h09;
    recv_val[3] = 1'b1;
    txn(0, 1, 8'b11_000000, 0, 1, 8'b11_000111, 1);
    recv_val[3] = 1'b0;
    check("occ_const", 32'(recv_rdy), 32'hF);
    recv1(3, 6'h0A);
    check("cm3_full", 32'(recv_rdy), 32'h7);
    txn(0, 1, 8'b11_000000, 0, 1, 8'b11_001001, 1);
    txn(0, 1, 8'b11_000000, 0, 1, 8'b11_001010, 1);
    send_rdy = 4'hF;
    cyc(2);
    send_rdy = '0;
    check("sim_drained", 32'(send_val), 32'h0);

    // 6 Async reset mid-stream
    txn(1, 0, 8'b01_010101, 1, 0, 8'h00, 1);
    recv1(2, 6'h0C);
    txn(0, 1, 8'b00_000000, 0, 0, 8'h00, 1);
    check("pre_rst_udf", 32'(err_udf), 32'h1);
    pull_en = 1'b1; val_rd = 1'b1; push_data = 8'b10_000000;
    #1;
    check("pre_rst_pull_val", 32'(pull_val), 32'h1);
    check("pre_rst_pull_data", 32'(pull_data), 32'b10_001100);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_pull_val", 32'(pull_val), 32'h0);
    check("arst_pull_data", 32'(pull_data), 32'h0);
    check("arst_send_val", 32'(send_val), 32'h0);
    check("arst_parity", 32'(parity), 32'h0);
    check("arst_recv_rdy", 32'(recv_rdy), 32'h0);
    check("arst_spc", 32'(pull_spc), 32'h0);
    check("arst_errs", 32'({err_ovf, err_udf}), 32'h0);
    pull_en = 1'b0; val_rd = 1'b0; push_data = '0;
    exp_send_q.delete();
    exp_pull_q.delete();
    cyc(2);
    reset_n = 1'b1;
    #1;
    check("post_rst_recv_rdy", 32'(recv_rdy), 32'hF);
    check("post_rst_send_val", 32'(send_val), 32'h0);
    check("post_rst_spc", 32'(pull_spc), 32'h1);
    cyc(1);
    txn(0, 1, 8'b10_000000, 0, 0, 8'h00, 1);
    check("post_rst_cm_empty", 32'(err_udf), 32'h1);

    cyc(3);
    check("send_q_empty", 32'(exp_send_q.size()), 32'h0);
    check("pull_q_empty", 32'(exp_pull_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
